// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and constants for the key event decoder
package key_pkg;

  localparam int CNT_W = 27;

  localparam logic [CNT_W-1:0] LONG_MAX_DEFAULT = 27'd99_999_999;
  localparam logic [CNT_W-1:0] GAP_MAX_DEFAULT  = 27'd14_999_999;
  localparam logic [CNT_W-1:0] REL_MAX_DEFAULT  = 27'd999_999;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    HOLD   = 3'd2,
    GAP    = 3'd3,
    PRESS2 = 3'd4
  } state_t;

  // Counters stick at all-ones rather than wrapping back into a valid count.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/key_release_det.sv
// rtl/key_release_det.sv - counts consecutive released cycles and confirms a release
module key_release_det
  import key_pkg::*;
#(
  parameter logic [CNT_W-1:0] REL_MAX = REL_MAX_DEFAULT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_active,
  input  logic i_clear,
  input  logic i_key_in,
  output logic o_release_ok
);

  localparam logic [CNT_W-1:0] REL_LAST = REL_MAX - CNT_W'(1);

  logic [CNT_W-1:0] r_rel;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rel <= '0;
    end else if (i_clear || !i_key_in || !i_active) begin
      r_rel <= '0;
    end else begin
      r_rel <= sat_inc(r_rel);
    end
  end

  assign o_release_ok = i_active && i_key_in && (r_rel == REL_LAST);

endmodule

// File: rtl/key_event_decoder.sv
// rtl/key_event_decoder.sv - classifies confirmed presses into short, double and long events
module key_event_decoder
  import key_pkg::*;
#(
  parameter logic [CNT_W-1:0] LONG_MAX = LONG_MAX_DEFAULT,
  parameter logic [CNT_W-1:0] GAP_MAX  = GAP_MAX_DEFAULT,
  parameter logic [CNT_W-1:0] REL_MAX  = REL_MAX_DEFAULT
) (
  input  logic sys_clock,
  input  logic sys_rst,
  input  logic key_in,
  input  logic key_flag,
  output logic short_flag,
  output logic double_flag,
  output logic long_flag
);

  localparam logic [CNT_W-1:0] LONG_LAST = LONG_MAX - CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_LAST  = GAP_MAX - CNT_W'(1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_next;
  logic             r_short;
  logic             r_double;
  logic             r_long;
  logic             w_short;
  logic             w_double;
  logic             w_long;
  logic             w_active;
  logic             w_clear;
  logic             w_release_ok;

  assign w_active = (r_state == PRESS1) || (r_state == HOLD) || (r_state == PRESS2);
  assign w_clear  = (w_next != r_state);

  key_release_det #(
    .REL_MAX (REL_MAX)
  ) u_release_det (
    .i_clk        (sys_clock),
    .i_rst        (sys_rst),
    .i_active     (w_active),
    .i_clear      (w_clear),
    .i_key_in     (key_in),
    .o_release_ok (w_release_ok)
  );

  always_ff @(posedge sys_clock) begin
    if (sys_rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_cnt    <= w_cnt_next;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
    end
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_short    = 1'b0;
    w_double   = 1'b0;
    w_long     = 1'b0;
    case (r_state)
      IDLE: begin
        if (key_flag) begin
          w_next     = PRESS1;
          w_cnt_next = '0;
        end
      end
      PRESS1: begin
        // Long wins: a release confirming on the same edge is ignored.
        if (!key_in && (r_cnt == LONG_LAST)) begin
          w_long = 1'b1;
          w_next = HOLD;
        end else if (w_release_ok) begin
          w_next     = GAP;
          w_cnt_next = '0;
        end else if (!key_in) begin
          w_cnt_next = sat_inc(r_cnt);
        end
      end
      HOLD: begin
        if (w_release_ok) begin
          w_next = IDLE;
        end
      end
      GAP: begin
        if (key_flag) begin
          w_next = PRESS2;
        end else if (r_cnt == GAP_LAST) begin
          w_short = 1'b1;
          w_next  = IDLE;
        end else begin
          w_cnt_next = sat_inc(r_cnt);
        end
      end
      PRESS2: begin
        if (w_release_ok) begin
          w_double = 1'b1;
          w_next   = IDLE;
        end
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  assign short_flag  = r_short;
  assign double_flag = r_double;
  assign long_flag   = r_long;

endmodule

// File: tb/tb_key_event_decoder.sv
// tb/tb_key_event_decoder.sv - self-checking bench for key_event_decoder
module tb_key_event_decoder;

  localparam int LONG_MAX = 100;
  localparam int GAP_MAX  = 50;
  localparam int REL_MAX  = 10;

  localparam int M_IDLE   = 0;
  localparam int M_FIRST  = 1;
  localparam int M_LONG   = 2;
  localparam int M_WAIT   = 3;
  localparam int M_SECOND = 4;

  logic sys_clock = 1'b0;
  logic sys_rst   = 1'b1;
  logic key_in    = 1'b1;
  logic key_flag  = 1'b0;
  logic short_flag;
  logic double_flag;
  logic long_flag;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int n_s, n_d, n_l;
  int s_cyc, d_cyc, l_cyc;
  int t_flag, rise;

  int m_phase = M_IDLE;
  int m_t     = 0;
  int m_run   = 0;
  bit e_s, e_d, e_l;

  key_event_decoder #(
    .LONG_MAX (27'd100),
    .GAP_MAX  (27'd50),
    .REL_MAX  (27'd10)
  ) dut (
    .sys_clock   (sys_clock),
    .sys_rst     (sys_rst),
    .key_in      (key_in),
    .key_flag    (key_flag),
    .short_flag  (short_flag),
    .double_flag (double_flag),
    .long_flag   (long_flag)
  );

  always #5 sys_clock = ~sys_clock;

  // Reference: a gesture tracker driven by the sampled inputs of one clock edge.
  task automatic model_step(input bit r, input bit ki, input bit kf);
    int  prev;
    bit  pressing;
    bit  released;
    e_s = 0; e_d = 0; e_l = 0;
    if (r) begin
      m_phase = M_IDLE; m_t = 0; m_run = 0;
      return;
    end
    prev     = m_phase;
    pressing = (prev == M_FIRST) || (prev == M_LONG) || (prev == M_SECOND);
    released = pressing && ki && (m_run == REL_MAX - 1);
    if (prev == M_IDLE) begin
      if (kf) begin m_phase = M_FIRST; m_t = 0; end
    end else if (prev == M_FIRST) begin
      if (!ki && m_t == LONG_MAX - 1) begin e_l = 1; m_phase = M_LONG; end
      else if (released) begin m_phase = M_WAIT; m_t = 0; end
      else if (!ki) m_t++;
    end else if (prev == M_LONG) begin
      if (released) m_phase = M_IDLE;
    end else if (prev == M_WAIT) begin
      if (kf) m_phase = M_SECOND;
      else if (m_t == GAP_MAX - 1) begin e_s = 1; m_phase = M_IDLE; end
      else m_t++;
    end else begin
      if (released) begin e_d = 1; m_phase = M_IDLE; end
    end
    if (m_phase != prev || !ki || !pressing) m_run = 0;
    else m_run++;
  endtask

  task automatic step(input bit ki, input bit kf, input bit r = 1'b0);
    key_in   = ki;
    key_flag = kf;
    sys_rst  = r;
    @(posedge sys_clock);
    model_step(r, ki, kf);
    cyc++;
    #1;
    checks++;
    assert ({short_flag, double_flag, long_flag} === {e_s, e_d, e_l}) else begin
      failures++;
      $error("FAIL flags cyc=%0d observed=%b%b%b expected=%b%b%b",
             cyc, short_flag, double_flag, long_flag, e_s, e_d, e_l);
    end
    checks++;
    assert ($countones({short_flag, double_flag, long_flag}) <= 1) else begin
      failures++;
      $error("FAIL onehot cyc=%0d observed=%b%b%b expected=at most one",
             cyc, short_flag, double_flag, long_flag);
    end
    if (short_flag === 1'b1)  begin n_s++; s_cyc = cyc; end
    if (double_flag === 1'b1) begin n_d++; d_cyc = cyc; end
    if (long_flag === 1'b1)   begin n_l++; l_cyc = cyc; end
  endtask

  task automatic click(input int hold);
    step(1'b0, 1'b1);
    t_flag = cyc;
    repeat (hold - 1) step(1'b0, 1'b0);
  endtask

  task automatic clear_counts();
    n_s = 0; n_d = 0; n_l = 0;
    s_cyc = -1; d_cyc = -1; l_cyc = -1;
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    clear_counts();
    step(1'b1, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1);
    check_int("reset_flags", int'({short_flag, double_flag, long_flag}), 0);
    repeat (5) step(1'b1, 1'b0);

    // Single click
    clear_counts();
    click(20);
    repeat (120) step(1'b1, 1'b0);
    check_int("single_short_count", n_s, 1);
    check_int("single_short_latency", s_cyc - t_flag, 20 + REL_MAX + GAP_MAX - 1);
    check_int("single_other", n_d + n_l, 0);

    // Double click: second press 30 cycles into the gap
    clear_counts();
    click(20);
    repeat (REL_MAX + 30) step(1'b1, 1'b0);
    click(15);
    rise = cyc + 1;
    repeat (40) step(1'b1, 1'b0);
    check_int("double_count", n_d, 1);
    check_int("double_latency", d_cyc - rise, REL_MAX - 1);
    check_int("double_other", n_s + n_l, 0);

    // Long press, then release must stay silent
    clear_counts();
    click(300);
    repeat (100) step(1'b1, 1'b0);
    check_int("long_count", n_l, 1);
    check_int("long_latency", l_cyc - t_flag, LONG_MAX);
    check_int("long_other", n_s + n_d, 0);

    // Release bounce one cycle short of confirmation
    clear_counts();
    click(20);
    repeat (REL_MAX - 1) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    rise = cyc + 1;
    repeat (REL_MAX + GAP_MAX + 20) step(1'b1, 1'b0);
    check_int("bounce_short_count", n_s, 1);
    check_int("bounce_short_latency", s_cyc - rise, REL_MAX - 1 + GAP_MAX);

    // key_flag on the gap timeout cycle
    clear_counts();
    click(20);
    repeat (REL_MAX + GAP_MAX - 1) step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    rise = cyc + 1;
    repeat (30) step(1'b1, 1'b0);
    check_int("collision_short", n_s, 0);
    check_int("collision_double", n_d, 1);
    check_int("collision_double_latency", d_cyc - rise, REL_MAX - 1);

    // Reset in the middle of a long press
    clear_counts();
    click(60);
    step(1'b0, 1'b0, 1'b1);
    repeat (150) step(1'b0, 1'b0);
    repeat (30) step(1'b1, 1'b0);
    check_int("reset_hold_flags", n_s + n_d + n_l, 0);
    clear_counts();
    click(20);
    repeat (100) step(1'b1, 1'b0);
    check_int("after_reset_short", n_s, 1);
    check_int("after_reset_latency", s_cyc - t_flag, 20 + REL_MAX + GAP_MAX - 1);

    // Random gestures with bounces, stray flags and mixed gaps
    for (int g = 0; g < 30; g++) begin
      click(int'($urandom_range(1, 130)));
      if ($urandom_range(0, 2) == 0) begin
        repeat ($urandom_range(1, 12)) step(1'b1, 1'b0);
        repeat ($urandom_range(1, 3)) step(1'b0, ($urandom_range(0, 3) == 0));
      end
      repeat ($urandom_range(1, 80)) step(1'b1, 1'b0);
      if ($urandom_range(0, 1) == 1) begin
        click(int'($urandom_range(1, 40)));
        repeat ($urandom_range(5, 25)) step(1'b1, 1'b0);
      end
      repeat ($urandom_range(0, 70)) step(1'b1, 1'b0);
    end
    repeat (200) step(1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
